// File: rtl/inst_loader.sv
// Front-end for the control FSM: synchronizes and debounces the shift/execute buttons,
// assembles a 16-bit LSB-first instruction from ser_in and holds it for execution.
module inst_loader #(
    parameter int DB_LEN = 4,
    parameter int DB_W   = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ser_in,
    input  logic        shift_btn,
    input  logic        exec_btn,
    input  logic        busy,
    output logic [3:0]  opcode,
    output logic [11:0] instr,
    output logic        inst_done,
    output logic        btn_edge,
    output logic [4:0]  bit_count
);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_LOADING = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t state_r, state_next_s;

    logic ser_meta_r, ser_sync_r, sh_meta_r, sh_sync_r, ex_meta_r, ex_sync_r;
    logic [DB_W-1:0] sh_cnt_r, ex_cnt_r;
    logic sh_db_r, ex_db_r, sh_db_d_r, ex_db_d_r, sh_pulse_r, busy_d_r;
    logic [15:0] shreg_r;
    logic [15:0] shreg_next_s;
    logic [4:0]  count_next_s;
    logic shift_en_s, load_done_s, release_s;

    assign shreg_next_s = {ser_sync_r, shreg_r[15:1]};

    // Two-flop synchronizers for the three asynchronous inputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {ser_meta_r, ser_sync_r} <= 2'b00;
            {sh_meta_r, sh_sync_r}   <= 2'b00;
            {ex_meta_r, ex_sync_r}   <= 2'b00;
        end else begin
            ser_meta_r <= ser_in;
            ser_sync_r <= ser_meta_r;
            sh_meta_r  <= shift_btn;
            sh_sync_r  <= sh_meta_r;
            ex_meta_r  <= exec_btn;
            ex_sync_r  <= ex_meta_r;
        end
    end

    // Shift-button debounce: level flips only after DB_LEN cycles of disagreement
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_cnt_r <= '0;
            sh_db_r  <= 1'b0;
        end else if (sh_sync_r == sh_db_r) begin
            sh_cnt_r <= '0;
        end else if (sh_cnt_r == DB_W'(DB_LEN - 1)) begin
            sh_cnt_r <= '0;
            sh_db_r  <= ~sh_db_r;
        end else begin
            sh_cnt_r <= sh_cnt_r + DB_W'(1);
        end
    end

    // Execute-button debounce, independent of the shift button
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_cnt_r <= '0;
            ex_db_r  <= 1'b0;
        end else if (ex_sync_r == ex_db_r) begin
            ex_cnt_r <= '0;
        end else if (ex_cnt_r == DB_W'(DB_LEN - 1)) begin
            ex_cnt_r <= '0;
            ex_db_r  <= ~ex_db_r;
        end else begin
            ex_cnt_r <= ex_cnt_r + DB_W'(1);
        end
    end

    // Rising-edge pulses of the debounced levels and busy history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_db_d_r  <= 1'b0;
            ex_db_d_r  <= 1'b0;
            sh_pulse_r <= 1'b0;
            btn_edge   <= 1'b0;
            busy_d_r   <= 1'b0;
        end else begin
            sh_db_d_r  <= sh_db_r;
            ex_db_d_r  <= ex_db_r;
            sh_pulse_r <= sh_db_r & ~sh_db_d_r;
            btn_edge   <= ex_db_r & ~ex_db_d_r;
            busy_d_r   <= busy;
        end
    end

    // Load state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_EMPTY: begin
                if (sh_pulse_r && !busy) state_next_s = S_LOADING;
                else                     state_next_s = S_EMPTY;
            end
            S_LOADING: begin
                if (sh_pulse_r && !busy && bit_count == 5'd15) state_next_s = S_FULL;
                else                                           state_next_s = S_LOADING;
            end
            S_FULL: begin
                if (busy_d_r && !busy) state_next_s = S_EMPTY;
                else                   state_next_s = S_FULL;
            end
            default: state_next_s = S_EMPTY;
        endcase
    end

    // Datapath enables decoded from the current state
    always_comb begin
        shift_en_s   = 1'b0;
        load_done_s  = 1'b0;
        release_s    = 1'b0;
        count_next_s = bit_count;
        case (state_r)
            S_EMPTY: begin
                shift_en_s   = sh_pulse_r & ~busy;
                count_next_s = 5'd1;
            end
            S_LOADING: begin
                shift_en_s   = sh_pulse_r & ~busy;
                load_done_s  = sh_pulse_r & ~busy & (bit_count == 5'd15);
                count_next_s = bit_count + 5'd1;
            end
            S_FULL: begin
                release_s = busy_d_r & ~busy;
            end
            default: begin
                shift_en_s = 1'b0;
            end
        endcase
    end

    // Shift register, bit counter and hold register; outputs change only on a full load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_r   <= 16'h0000;
            bit_count <= 5'd0;
            opcode    <= 4'h0;
            instr     <= 12'h000;
            inst_done <= 1'b0;
        end else begin
            if (shift_en_s) begin
                shreg_r   <= shreg_next_s;
                bit_count <= count_next_s;
            end else if (release_s) begin
                bit_count <= 5'd0;
            end else begin
                bit_count <= bit_count;
            end
            if (load_done_s) begin
                opcode    <= shreg_next_s[3:0];
                instr     <= shreg_next_s[15:4];
                inst_done <= 1'b1;
            end else if (release_s) begin
                inst_done <= 1'b0;
            end else begin
                inst_done <= inst_done;
            end
        end
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Front-end stage that feeds the control FSM.
- Synchronizes and debounces two raw pushbuttons: "shift" and "execute".
- Assembles a 16-bit instruction from the serial data pin, one bit per shift press, LSB first.
- Presents opcode[3:0] and instr[11:0] with an inst_done flag, and a one-cycle btn_edge pulse from the execute button.

Parameters:
- DB_LEN, 4: consecutive cycles a synchronized input must hold a new level before its debounced level changes.
- DB_W, 3: width of each debounce counter; must satisfy 2^DB_W > DB_LEN.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- ser_in  input  1  raw serial instruction data bit, asynchronous.
- shift_btn  input  1  raw button, asynchronous; each press clocks in one ser_in bit.
- exec_btn  input  1  raw button, asynchronous; execute request.
- busy  input  1  high while the control FSM is outside its idle state.
- opcode  output  4  captured instruction bits [3:0].
- instr  output  12  captured instruction bits [15:4].
- inst_done  output  1  high while a complete 16-bit instruction is held.
- btn_edge  output  1  one-cycle pulse per debounced exec_btn press.
- bit_count  output  5  bits received for the instruction in progress, 0..16.

Behaviour:
- Reset: all outputs 0, shift register 0, debounced levels 0, state S_EMPTY.
- Synchronizers:
  - ser_in, shift_btn and exec_btn each pass through a 2-flop synchronizer.
  - Synchronizer flops reset to 0.
- Debounce (shift_btn and exec_btn, each independent):
  - The counter clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments; when it reaches DB_LEN-1 the debounced level flips on the next edge and the counter clears.
  - Glitches shorter than DB_LEN cycles never change the debounced level.
- Edge pulses:
  - A debounced 0->1 transition yields exactly one cycle of sh_pulse (internal) or btn_edge.
  - Falling transitions yield nothing.
  - Input-to-pulse latency is 2 (sync) + DB_LEN + 1 cycles.
- btn_edge:
  - Generated in every state, regardless of busy or inst_done.
  - The consuming FSM qualifies it with inst_done.
- States:
  - S_EMPTY: on sh_pulse with busy=0, shift in the bit, set bit_count=1, go to S_LOADING.
  - S_LOADING: on sh_pulse with busy=0, shreg <= {ser_sync, shreg[15:1]} and bit_count += 1. When the bit that makes bit_count 16 is accepted:
    - the hold register captures the new shreg value on that same edge (ser_sync lands in bit 15);
    - inst_done=1 on the following cycle;
    - go to S_FULL.
  - S_FULL: sh_pulse is ignored; bit_count stays at 16. On a busy falling edge (busy was 1, now 0): inst_done=0, bit_count=0, go to S_EMPTY.
- Bit sampling: the shifted bit is the synchronized ser_in value in the cycle sh_pulse is high.
- Output stability:
  - opcode and instr come from the hold register only.
  - They are stable throughout loading and execution, changing only at completion of the next 16-bit load.
  - Partial loads never disturb them.
- busy=1 in S_EMPTY or S_LOADING: sh_pulse is ignored and no state change occurs.
- sh_pulse and btn_edge in the same cycle: both take effect independently.
- Reset mid-load: everything clears as at power-up, including the hold register; opcode=0, instr=0.
- No wrap-around: bit_count never exceeds 16.

Test Plan:
- Reset, then 16 shift presses with bits LSB-first of 0x1234 -> bit_count steps 1..16; after the final bit, opcode=4'h4, instr=12'h123, inst_done=1 on the next cycle.
- Load 0x8A51, then a 17th shift press with ser_in=1 -> opcode=4'h1, instr=12'h8A5 unchanged; bit_count=16.
- shift_btn glitch high for DB_LEN-1 cycles -> no shift, bit_count unchanged. Then high for DB_LEN+2 cycles -> exactly one bit accepted, pulse at 2+DB_LEN+1 cycles after the rising edge.
- exec_btn pressed while inst_done=1 -> btn_edge high exactly 1 cycle. Drive busy=1 for 20 cycles, then 0 -> inst_done=0, bit_count=0, opcode/instr retain the last values.
- Mid-load with bit_count=7, pull rstn low asynchronously -> all outputs 0 immediately. After release, a fresh 16-bit load of 0xFFFF -> opcode=4'hF, instr=12'hFFF.
- busy=1 during S_LOADING with 3 shift presses -> bit_count unchanged. shift_btn and exec_btn pulses in the same cycle after busy=0 -> bit accepted and btn_edge pulses together.
